// File: rtl/tmp_readout.sv
// Temperature sensor readout: counts sink/source toggles between phase markers and emits a signed code.
// Optional windowed averaging is enabled with macro TMP_READOUT_AVG_EN.
module tmp_readout #(
  parameter int CNT_W    = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PA,
  input  logic               PB,
  input  logic               PC,
  input  logic               PD,
  input  logic               snk,
  input  logic               src_n,
  input  logic               preChrg,
  output logic [CNT_W:0]     code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               ovf,
  output logic               sat
);

  localparam int CODE_W = CNT_W + 1;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_ACQ  = 1'b1;

  if (CNT_W < 1 || AVG_LOG2 < 0) begin : g_param_chk
    $error("tmp_readout: CNT_W must be >= 1 and AVG_LOG2 >= 0");
  end

  logic pa_q, pb_q, pc_q, pd_q, snk_q, src_n_q, pre_q;
  logic snk_prev_q, src_n_prev_q, marker_prev_q;
  logic [0:0] state_q, state_d;
  logic [CNT_W-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic [CNT_W-1:0] up_now, dn_now;
  logic [CODE_W-1:0] code_q, code_d;
  logic code_valid_q, code_valid_d;
  logic ovf_q, ovf_d, sat_q, sat_d;

  logic marker, marker_rise;
  logic up_inc, dn_inc, sat_hit;
  logic signed [CODE_W-1:0] win_res;
  logic win_res_vld;
  logic res_vld;
  logic [CODE_W-1:0] res_code;

  // Stage 1: edge detection and toggle counting on the registered inputs
  always_comb begin
    marker      = pb_q & pc_q & pd_q & ~pa_q;
    marker_rise = marker & ~marker_prev_q;
    up_inc      = (state_q == ST_ACQ) & (src_n_q ^ src_n_prev_q) & ~pre_q;
    dn_inc      = (state_q == ST_ACQ) & (snk_q ^ snk_prev_q) & ~pre_q;
    sat_hit     = (up_inc & (&up_cnt_q)) | (dn_inc & (&dn_cnt_q));
    up_now      = (up_inc && !(&up_cnt_q)) ? up_cnt_q + CNT_W'(1) : up_cnt_q;
    dn_now      = (dn_inc && !(&dn_cnt_q)) ? dn_cnt_q + CNT_W'(1) : dn_cnt_q;
    win_res     = $signed({1'b0, up_now}) - $signed({1'b0, dn_now});
  end

  always_comb begin
    state_d     = state_q;
    up_cnt_d    = up_now;
    dn_cnt_d    = dn_now;
    win_res_vld = 1'b0;
    if (pre_q) begin
      state_d  = ST_SYNC;
      up_cnt_d = '0;
      dn_cnt_d = '0;
    end else if (state_q == ST_SYNC) begin
      up_cnt_d = '0;
      dn_cnt_d = '0;
      if (marker_rise) state_d = ST_ACQ;
    end else if (marker_rise) begin
      win_res_vld = 1'b1;
      up_cnt_d    = '0;
      dn_cnt_d    = '0;
    end
  end

`ifdef TMP_READOUT_AVG_EN
  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam int WIN_W = AVG_LOG2 + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, acc_shr;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

  // Stage 2: accumulate window results and emit the mean every 2^AVG_LOG2 windows
  always_comb begin
    acc_sum   = acc_q + ACC_W'(win_res);
    acc_shr   = acc_sum >>> AVG_LOG2;
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    res_vld   = 1'b0;
    res_code  = acc_shr[CODE_W-1:0];
    if (pre_q) begin
      acc_d     = '0;
      win_cnt_d = '0;
    end else if (win_res_vld) begin
      if (win_cnt_q == WIN_LAST) begin
        res_vld   = 1'b1;
        acc_d     = '0;
        win_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        win_cnt_d = win_cnt_q + WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      win_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
    end
  end
`else
  always_comb begin
    res_vld  = win_res_vld;
    res_code = win_res;
  end
`endif

  // Stage 3: output register with valid/ready hold and drop-on-full
  always_comb begin
    code_d       = code_q;
    code_valid_d = code_valid_q;
    ovf_d        = ovf_q;
    sat_d        = sat_q | sat_hit;
    if (res_vld) begin
      if (!code_valid_q || code_ready) begin
        code_d       = res_code;
        code_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (code_valid_q && code_ready) begin
      code_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pa_q          <= 1'b0;
      pb_q          <= 1'b0;
      pc_q          <= 1'b0;
      pd_q          <= 1'b0;
      snk_q         <= 1'b0;
      src_n_q       <= 1'b0;
      pre_q         <= 1'b0;
      snk_prev_q    <= 1'b0;
      src_n_prev_q  <= 1'b0;
      marker_prev_q <= 1'b0;
      state_q       <= ST_SYNC;
      up_cnt_q      <= '0;
      dn_cnt_q      <= '0;
      code_q        <= '0;
      code_valid_q  <= 1'b0;
      ovf_q         <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      pa_q          <= PA;
      pb_q          <= PB;
      pc_q          <= PC;
      pd_q          <= PD;
      snk_q         <= snk;
      src_n_q       <= src_n;
      pre_q         <= preChrg;
      snk_prev_q    <= snk_q;
      src_n_prev_q  <= src_n_q;
      marker_prev_q <= marker;
      state_q       <= state_d;
      up_cnt_q      <= up_cnt_d;
      dn_cnt_q      <= dn_cnt_d;
      code_q        <= code_d;
      code_valid_q  <= code_valid_d;
      ovf_q         <= ovf_d;
      sat_q         <= sat_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign ovf        = ovf_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_tmp_readout.sv
// Directed bench for tmp_readout: an 8-bit-counter instance and a 4-bit-counter instance share stimulus.
module tb_tmp_readout;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic PA = 1'b0, PB = 1'b0, PC = 1'b0, PD = 1'b0;
  logic snk = 1'b0, src_n = 1'b0, preChrg = 1'b0, code_ready = 1'b0;

  logic [8:0] code8;
  logic       valid8, ovf8, sat8;
  logic [4:0] code4;
  logic       valid4, ovf4, sat4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  tmp_readout #(.CNT_W(8), .AVG_LOG2(2)) u_dut8 (
    .clk(clk), .reset(reset), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .snk(snk), .src_n(src_n), .preChrg(preChrg),
    .code(code8), .code_valid(valid8), .code_ready(code_ready),
    .ovf(ovf8), .sat(sat8)
  );

  tmp_readout #(.CNT_W(4), .AVG_LOG2(2)) u_dut4 (
    .clk(clk), .reset(reset), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .snk(snk), .src_n(src_n), .preChrg(preChrg),
    .code(code4), .code_valid(valid4), .code_ready(code_ready),
    .ovf(ovf4), .sat(sat4)
  );

  task automatic check_vec(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    {PA, PB, PC, PD, snk, src_n, preChrg, code_ready} = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic mark(input int hold = 1);
    PA = 1'b0; PB = 1'b1; PC = 1'b1; PD = 1'b1;
    tick(hold);
    PB = 1'b0; PC = 1'b0; PD = 1'b0;
  endtask

  task automatic tgl_src(input int n);
    for (int i = 0; i < n; i++) begin
      src_n = ~src_n;
      tick(1);
    end
  endtask

  task automatic tgl_snk(input int n);
    for (int i = 0; i < n; i++) begin
      snk = ~snk;
      tick(1);
    end
  endtask

  task automatic tgl_both(input int n);
    for (int i = 0; i < n; i++) begin
      snk = ~snk;
      src_n = ~src_n;
      tick(1);
    end
  endtask

  initial begin
    tick(1);
    do_reset();
    check_vec("rst_code", int'($signed(code8)), 0);
    check_vec("rst_valid", int'(valid8), 0);
    check_vec("rst_ovf", int'(ovf8), 0);
    check_vec("rst_sat", int'(sat8), 0);

`ifdef TMP_READOUT_AVG_EN
    // Windows +4,+5,+6,+7 average to 22>>>2 = 5
    mark(); tgl_src(4);
    mark(); tick(1);
    check_vec("avg_no_early_1", int'(valid8), 0);
    tgl_src(5); mark(); tick(1);
    check_vec("avg_no_early_2", int'(valid8), 0);
    tgl_src(6); mark(); tick(1);
    check_vec("avg_no_early_3", int'(valid8), 0);
    tgl_src(7); mark();
    check_vec("avg_latency", int'(valid8), 0);
    tick(1);
    check_vec("avg_valid", int'(valid8), 1);
    check_vec("avg_code", int'($signed(code8)), 5);
    check_vec("avg_ovf", int'(ovf8), 0);
`else
    // +10 -3 window
    mark(); tgl_src(10); tgl_snk(3); mark();
    check_vec("w7_latency", int'(valid8), 0);
    tick(1);
    check_vec("w7_valid", int'(valid8), 1);
    check_vec("w7_code", int'($signed(code8)), 7);
    tick(2);
    check_vec("w7_hold", int'($signed(code8)), 7);
    code_ready = 1'b1; tick(1); code_ready = 1'b0;
    check_vec("w7_consumed", int'(valid8), 0);

    // Simultaneous toggles both count: 3 up, 4 down
    do_reset();
    mark(); tgl_both(3); tgl_snk(1); mark(); tick(1);
    check_vec("both_code", int'($signed(code8)), -1);

    // Pre-sync toggles ignored
    do_reset();
    tgl_src(5); mark(); tgl_snk(2); mark(); tick(1);
    check_vec("neg_valid", int'(valid8), 1);
    check_vec("neg_code", int'($signed(code8)), -2);

    // Back-pressure: second result dropped
    do_reset();
    mark(); tgl_src(4); mark(); tgl_src(9); mark(); tick(1);
    check_vec("bp_code", int'($signed(code8)), 4);
    check_vec("bp_valid", int'(valid8), 1);
    check_vec("bp_ovf", int'(ovf8), 1);
    code_ready = 1'b1; tick(1); code_ready = 1'b0;
    check_vec("bp_drain", int'(valid8), 0);
    check_vec("bp_ovf_sticky", int'(ovf8), 1);

    // Saturation on the 4-bit instance
    do_reset();
    mark(); tgl_src(20); mark(); tick(1);
    check_vec("sat4_code", int'($signed(code4)), 15);
    check_vec("sat4_flag", int'(sat4), 1);
    check_vec("sat8_code", int'($signed(code8)), 20);
    check_vec("sat8_flag", int'(sat8), 0);

    // Precharge mid-window discards partial count
    do_reset();
    mark(); tgl_src(6);
    preChrg = 1'b1; tick(1); preChrg = 1'b0;
    tick(1);
    mark(); tick(1);
    check_vec("pre_no_result", int'(valid8), 0);
    tgl_src(2); mark(); tick(1);
    check_vec("pre_valid", int'(valid8), 1);
    check_vec("pre_code", int'($signed(code8)), 2);

    // Reset mid-window: partial window discarded
    do_reset();
    mark(); tgl_src(3);
    reset = 1'b1; tick(1); reset = 1'b0;
    mark(); tick(2);
    check_vec("rstmid_valid", int'(valid8), 0);

    // Marker held high yields one rise only
    do_reset();
    mark(); tgl_src(2); mark(4); tick(3);
    check_vec("hold_code", int'($signed(code8)), 2);
    check_vec("hold_valid", int'(valid8), 1);
    check_vec("hold_ovf", int'(ovf8), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tmp_readout.md
TMP_READOUT -- requirements
Module: tmp_readout

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each toggle counter.
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of the number of windows averaged.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports PA, PB, PC, PD  input  1 each  sensor controller phase outputs.
REQ-006 SHALL have ports snk, src_n  input  1 each  sensor controller sink/source toggle outputs.
REQ-007 SHALL have port preChrg  input  1  sensor controller precharge indicator.
REQ-008 SHALL have port code  output  CNT_W+1  signed temperature code (two's complement).
REQ-009 SHALL have port code_valid  output  1  code holds an unconsumed result.
REQ-010 SHALL have port code_ready  input  1  consumer accepts code when code_valid=1.
REQ-011 SHALL have port ovf  output  1  sticky: a result was dropped.
REQ-012 SHALL have port sat  output  1  sticky: a counter saturated.

Function
REQ-013 SHALL register every input one stage before use; marker = PB & PC & PD & !PA on the registered values; marker-rise = marker=1 while previous-cycle marker=0.
REQ-014 SHALL detect a toggle on snk/src_n as registered value differing from previous-cycle registered value.
REQ-015 SHALL implement states SYNC and ACQ; SYNC->ACQ on marker-rise with both counters cleared; toggles ignored in SYNC.
REQ-016 In ACQ, SHALL increment up_cnt per src_n toggle and dn_cnt per snk toggle; simultaneous toggles SHALL both count.
REQ-017 Counters SHALL saturate at 2^CNT_W-1 and set sat; no wrap-around.
REQ-018 On marker-rise in ACQ, SHALL form window result = up_cnt - dn_cnt (CNT_W+1 signed, including any toggle in that cycle), clear both counters, remain in ACQ.
REQ-019 A new result SHALL load code and set code_valid one cycle after the marker-rise cycle.
REQ-020 code_valid SHALL stay 1 and code stable until the cycle where code_valid & code_ready; code_valid then clears unless a new result loads in that same cycle, in which case the new result loads and code_valid stays 1.
REQ-021 If a new result arrives while code_valid=1 and code_ready=0, the new result SHALL be dropped, code retained, ovf set.
REQ-022 preChrg=1 in any state SHALL force SYNC and clear counters and accumulator next cycle; code, code_valid, ovf, sat unaffected.
REQ-023 Marker held high across several cycles SHALL produce exactly one marker-rise.

Reset
REQ-024 On reset=1 at a clock edge: state=SYNC, counters, accumulator, window count, input registers=0; code=0, code_valid=0, ovf=0, sat=0.
REQ-025 Reset mid-window SHALL discard the partial window; no result emitted.

Configuration
REQ-026 With macro TMP_READOUT_AVG_EN defined, window results SHALL accumulate in a (CNT_W+1+AVG_LOG2)-bit signed accumulator; after 2^AVG_LOG2 windows, code = accumulator arithmetically shifted right by AVG_LOG2, then accumulator and window count clear.
REQ-027 Without TMP_READOUT_AVG_EN, every window result SHALL be emitted directly as code; AVG_LOG2 unused, no accumulator logic.

Verification
REQ-028 Reset, marker-rise, 10 src_n toggles, 3 snk toggles, marker-rise (macro off) -> code=+7, code_valid=1 one cycle later.
REQ-029 Toggles before first marker-rise (5 src_n), then window of 2 snk toggles (macro off) -> code=-2; pre-sync toggles ignored.
REQ-030 code_ready=0, two complete windows (+4 then +9) -> code=+4 retained, ovf=1; code_ready=1 -> code_valid=0 next cycle.
REQ-031 CNT_W=4, 20 src_n toggles in one window -> up_cnt=15, code=+15, sat=1.
REQ-032 Macro on, AVG_LOG2=2, windows +4,+5,+6,+7 -> single result code=+5 after fourth marker-rise; no result after first three.
REQ-033 preChrg pulse mid-window after 6 src_n toggles, then marker-rise, 2 src_n toggles, marker-rise -> code=+2.
